// File: rtl/vram_arbiter.sv
// Time-slices one registered RAM port between the video fetch path and the Z80.
// Phase 0 belongs to video unless vertical blank hands it to the CPU.
module vram_arbiter #(
   parameter int AW = 17,
   parameter int DW = 8
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          vid_ce,
   input  logic          vid_vb,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_dout,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } cpu_state_t;

   cpu_state_t    state;
   cpu_state_t    state_next;
   logic [1:0]    phase;
   logic          vid_slot;
   logic          grant;
   logic          vid_fetch;
   logic          issue_read;
   logic [DW-1:0] rdata_hold;

   assign vid_slot = (phase == 2'd0) && !vid_vb;

   // Slot counter realigns to the pixel strobe, free-runs otherwise
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         phase <= 2'd0;
      end else if (vid_ce) begin
         phase <= 2'd0;
      end else begin
         phase <= phase + 2'd1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grant is gated by reset so nothing reaches the RAM while held in reset
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      case (state)
         IDLE: begin
            if (reset_n && cpu_req && !vid_slot) begin
               grant      = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_addr  = vid_addr;
      mem_we    = 1'b0;
      mem_wdata = {DW{1'b0}};
      if (grant) begin
         mem_addr  = cpu_addr;
         mem_we    = cpu_we;
         mem_wdata = cpu_wdata;
      end
   end

   assign cpu_ack = (state == ISSUE);

   // Read data is bypassed during the ack cycle and held in a register afterwards
   assign cpu_rdata = (cpu_ack && issue_read) ? mem_rdata : rdata_hold;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         vid_fetch  <= 1'b0;
         vid_dout   <= {DW{1'b0}};
         issue_read <= 1'b0;
         rdata_hold <= {DW{1'b0}};
      end else begin
         vid_fetch <= vid_slot;
         if (vid_fetch) begin
            vid_dout <= mem_rdata;
         end
         if (grant) begin
            issue_read <= !cpu_we;
         end
         if (cpu_ack && issue_read) begin
            rdata_hold <= mem_rdata;
         end
      end
   end

endmodule
